// File: rtl/framebuffer_port_arbiter_pkg.sv
// Shared types for the framebuffer port arbiter: starvation FSM states,
// grant sources and the fixed-priority grant decision.
package framebuffer_port_arbiter_pkg;

  localparam int COUNT_WIDTH = 8;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    FRAG_WR = 2'd1,
    FRAG_RD = 2'd2,
    BULK    = 2'd3
  } grant_t;

  // Fragment strobes can never be stalled, so they always outrank the bulk port.
  function automatic grant_t pick_grant(input logic frag_wr, input logic frag_rd,
                                        input logic bulk_valid);
    grant_t g;
    if (frag_wr)         g = FRAG_WR;
    else if (frag_rd)    g = FRAG_RD;
    else if (bulk_valid) g = BULK;
    else                 g = NONE;
    return g;
  endfunction

endpackage

// File: rtl/framebuffer_port_arbiter_starvation_monitor.sv
// Counts consecutive blocked bulk cycles and raises holdRequest once the
// limit is hit, until the bulk command is granted or withdrawn.
module starvation_monitor
  import framebuffer_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic bulk_valid,
  input  logic blocked,
  input  logic clear,
  output logic holdRequest
);

  localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(STARVE_LIMIT);

  arb_state_t             state, next_state;
  logic [COUNT_WIDTH-1:0] starve_count, next_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ARB;
      starve_count <= '0;
    end else begin
      state        <= next_state;
      starve_count <= next_count;
    end
  end

  // The count saturates at the limit, so it can never wrap back to zero.
  always_comb begin
    next_state = state;
    next_count = starve_count;
    case (state)
      ARB: begin
        if (clear || !bulk_valid) begin
          next_count = '0;
        end else if (blocked) begin
          next_count = (starve_count >= LIMIT) ? starve_count : starve_count + 1'b1;
          if (next_count >= LIMIT) next_state = HOLD;
        end
      end
      HOLD: begin
        if (clear || !bulk_valid) begin
          next_state = ARB;
          next_count = '0;
        end
      end
      default: begin
        next_state = ARB;
        next_count = '0;
      end
    endcase
  end

  always_comb begin
    holdRequest = (state == HOLD);
  end

endmodule

// File: rtl/framebuffer_port_arbiter.sv
// Shares one single-port memory between an unstallable fragment pipeline and
// a valid/ready bulk port that takes every idle memory cycle.
module framebuffer_port_arbiter
  import framebuffer_port_arbiter_pkg::*;
#(
  parameter int INDEX_WIDTH  = 14,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fragReadEnable,
  input  logic [INDEX_WIDTH-1:0] fragReadIndex,
  output logic [DATA_WIDTH-1:0]  fragReadData,
  input  logic                   fragWriteEnable,
  input  logic [INDEX_WIDTH-1:0] fragWriteIndex,
  input  logic [DATA_WIDTH-1:0]  fragWriteData,
  input  logic                   bulkCmdValid,
  output logic                   bulkCmdReady,
  input  logic                   bulkCmdWrite,
  input  logic [INDEX_WIDTH-1:0] bulkCmdIndex,
  input  logic [DATA_WIDTH-1:0]  bulkCmdData,
  output logic                   bulkRspValid,
  output logic [DATA_WIDTH-1:0]  bulkRspData,
  output logic [INDEX_WIDTH-1:0] memAddr,
  output logic                   memWriteEnable,
  output logic [DATA_WIDTH-1:0]  memWriteData,
  input  logic [DATA_WIDTH-1:0]  memReadData,
  output logic                   holdRequest,
  output logic                   collision
);

  grant_t                 grant;
  logic [INDEX_WIDTH-1:0] sel_addr;
  logic [INDEX_WIDTH-1:0] last_addr;
  logic                   sel_we;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   bulk_grant;
  logic                   rsp_tag;

  always_comb begin
    grant = pick_grant(fragWriteEnable, fragReadEnable, bulkCmdValid);
  end

  // With no grant the address bus parks on the last used address.
  always_comb begin
    sel_addr  = last_addr;
    sel_we    = 1'b0;
    sel_wdata = fragWriteData;
    case (grant)
      FRAG_WR: begin
        sel_addr  = fragWriteIndex;
        sel_we    = 1'b1;
        sel_wdata = fragWriteData;
      end
      FRAG_RD: begin
        sel_addr = fragReadIndex;
      end
      BULK: begin
        sel_addr  = bulkCmdIndex;
        sel_we    = bulkCmdWrite;
        sel_wdata = bulkCmdData;
      end
      default: begin
        sel_addr = last_addr;
      end
    endcase
  end

  always_comb begin
    bulkCmdReady   = bulkCmdValid & ~fragReadEnable & ~fragWriteEnable & ~reset;
    bulk_grant     = bulkCmdReady;
    memAddr        = reset ? '0 : sel_addr;
    memWriteEnable = sel_we & ~reset;
    memWriteData   = sel_wdata;
    fragReadData   = memReadData;
    bulkRspData    = memReadData;
    bulkRspValid   = rsp_tag;
  end

  // The tag remembers whose read is coming back so the two return paths never swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_addr <= '0;
      rsp_tag   <= 1'b0;
      collision <= 1'b0;
    end else begin
      last_addr <= sel_addr;
      rsp_tag   <= bulk_grant & ~bulkCmdWrite;
      if (fragReadEnable && fragWriteEnable) collision <= 1'b1;
    end
  end

  starvation_monitor #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starvation_monitor (
    .clk        (clk),
    .reset      (reset),
    .bulk_valid (bulkCmdValid),
    .blocked    (bulkCmdValid & ~bulkCmdReady),
    .clear      (bulk_grant),
    .holdRequest(holdRequest)
  );

endmodule

// File: doc/framebuffer_port_arbiter.md
# framebuffer_port_arbiter

Shares one single-port framebuffer or depth memory between the fragment pipeline and a bulk requester, such as a clear, flush or stream-out engine. The fragment pipeline runs with fixed bubble timing and cannot be stalled per access, so its read and write strobes always win. The bulk port uses a valid/ready handshake and gets every idle memory cycle. A starvation counter raises a hold request so the upstream fragment feeder inserts idle cycles until the bulk command is served.

## Interface
Parameters:
- INDEX_WIDTH, 14, memory word address width
- DATA_WIDTH, 16, memory word width
- STARVE_LIMIT, 15, number of consecutive blocked bulk cycles before `holdRequest` asserts; valid range 1..255

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- fragReadEnable  in  1  fragment read strobe
- fragReadIndex  in  INDEX_WIDTH  fragment read address
- fragReadData  out  DATA_WIDTH  memory read data, valid 1 cycle after a granted fragment read
- fragWriteEnable  in  1  fragment write strobe
- fragWriteIndex  in  INDEX_WIDTH  fragment write address
- fragWriteData  in  DATA_WIDTH  fragment write data
- bulkCmdValid  in  1  bulk command valid
- bulkCmdReady  out  1  bulk command accepted this cycle
- bulkCmdWrite  in  1  1 = write, 0 = read
- bulkCmdIndex  in  INDEX_WIDTH  bulk address
- bulkCmdData  in  DATA_WIDTH  bulk write data
- bulkRspValid  out  1  bulk read data valid
- bulkRspData  out  DATA_WIDTH  bulk read data
- memAddr  out  INDEX_WIDTH  memory address
- memWriteEnable  out  1  memory write strobe
- memWriteData  out  DATA_WIDTH  memory write data
- memReadData  in  DATA_WIDTH  memory read data, 1-cycle latency
- holdRequest  out  1  asks the upstream feeder to stop issuing fragments
- collision  out  1  sticky error flag

## Operation
- **Grant priority, combinational per cycle:**
  - fragWriteEnable is granted first.
  - fragReadEnable is granted next.
  - bulkCmdValid is granted last.
  - memAddr, memWriteEnable and memWriteData are muxed from the granted source. With no grant: memWriteEnable = 0 and memAddr holds its last value.
- **Bulk handshake:**
  - bulkCmdReady = bulkCmdValid & !fragReadEnable & !fragWriteEnable.
  - Transfer happens when valid and ready are both high.
  - After asserting bulkCmdValid, the requester holds the command stable until accepted.
- **Simultaneous fragment read and write:** this breaks the bubble contract. The write is granted, the read is dropped, and `collision` sets and stays set until reset.
- **Read return:**
  - A 1-bit register tags whether last cycle's granted read belonged to the bulk port.
  - fragReadData = memReadData, passed through with no register.
  - bulkRspValid = registered tag; bulkRspData = memReadData.
- **Starvation FSM, two states:**
  - ARB:
    - starveCount increments each cycle bulkCmdValid & !bulkCmdReady.
    - starveCount clears on a bulk grant or when bulkCmdValid = 0.
    - starveCount saturates at STARVE_LIMIT. On reaching STARVE_LIMIT it goes to HOLD.
  - HOLD:
    - holdRequest = 1.
    - Fragments already in flight keep priority.
    - On the bulk grant it goes to ARB, clears the counter and drops holdRequest the next cycle.
    - If bulkCmdValid falls without a grant, it also returns to ARB.
- **Counter width:** 8 bits, no wrap, because of saturation.

## Timing
- **Reset values:**
  - bulkRspValid = 0, holdRequest = 0, collision = 0, starveCount = 0, state = ARB.
  - memWriteEnable and bulkCmdReady are forced to 0 while reset is high.
  - memAddr = 0.
- **Latency:**
  - Bulk read: accept at cycle N, bulkRspValid at N+1.
  - Fragment read: issue at N, data at N+1.
  - Writes commit on the grant edge.
- **holdRequest timing:**
  - Asserts the cycle after the STARVE_LIMIT-th consecutive blocked cycle.
  - Deasserts the cycle after the bulk grant.
- **Bulk throughput:** with both fragment strobes low, the bulk port accepts one command per cycle.
- **Reset mid-operation:** a pending bulkRspValid is cleared and never emitted, and the bulk requester must reissue. collision clears.

## Structure
- A shared package holds:
  - the FSM state encoding (ARB, HOLD);
  - the grant-source encoding (NONE, FRAG_WR, FRAG_RD, BULK).
- One sub-module, `starvation_monitor`: counter, comparator and FSM, with outputs holdRequest and a clear input.
- The grant mux and the response tag stay in the top module.

## Test plan
- **Bulk only:** 4 writes with index 0..3 and data 0xA000+i, then 4 reads → memWriteEnable pulses on 4 cycles, bulkRspValid for 4 cycles with data 0xA000..0xA003, each one cycle after accept.
- **Fragment bubble pattern:** fragRead and fragWrite on alternating cycles, bulkCmdValid held → bulkCmdReady never 1. With STARVE_LIMIT = 15, holdRequest rises on the 16th cycle. Stop fragments → bulk accepted, holdRequest low the next cycle.
- **Simultaneous fragment read and write:** fragWriteIndex 0x10 with data 0x1234, fragReadIndex 0x20 → memAddr = 0x10, memWriteEnable = 1, collision = 1 and stays 1 for 100 cycles.
- **Interleaved gaps:** fragRead every other cycle plus a bulk read stream → bulk accepted only on idle cycles. The bulkRspValid/fragReadData returns are never swapped (tag check against a scoreboard).
- **Reset mid-read:** assert reset in the same cycle as a bulk read accept → bulkRspValid stays 0, all outputs at reset values while reset is high.
- **bulkCmdValid drops during HOLD:** → FSM returns to ARB, holdRequest falls, counter = 0.
